// File: rtl/mips_reg_file_mp.sv
// Multi-port MIPS GPR file: N_READ combinational read lanes, two write ports, clear FSM.
// Optional `REGFILE_BYPASS_EN forwards same-cycle write data to matching read lanes.
module mips_reg_file_mp #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int N_READ   = 2,
    parameter int ZERO_REG = 1
) (
    input  logic                       CLK,
    input  logic                       RESET,
    input  logic                       ClearReq,
    output logic                       Busy,
    input  logic                       WriteEn0,
    input  logic [ADDR_W-1:0]          WriteAddr0,
    input  logic [DATA_W-1:0]          WriteData0,
    input  logic                       WriteEn1,
    input  logic [ADDR_W-1:0]          WriteAddr1,
    input  logic [DATA_W-1:0]          WriteData1,
    input  logic [N_READ*ADDR_W-1:0]   ReadAddr,
    output logic [N_READ*DATA_W-1:0]   ReadData
);

    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic {IDLE, CLEAR} stateT;

    stateT             state;
    stateT             nextState;
    logic [ADDR_W-1:0] clrPtr;
    logic [ADDR_W-1:0] nextClrPtr;
    logic              wr0Ok;
    logic              wr1Ok;

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state  <= CLEAR;
            clrPtr <= '0;
        end else begin
            state  <= nextState;
            clrPtr <= nextClrPtr;
        end
    end

    // The last clear cycle is the one writing the top register; ClearReq is ignored while clearing.
    always_comb begin
        nextState  = state;
        nextClrPtr = clrPtr;
        case (state)
            IDLE: begin
                if (ClearReq) begin
                    nextState  = CLEAR;
                    nextClrPtr = '0;
                end
            end
            CLEAR: begin
                nextClrPtr = clrPtr + 1'b1;
                if (&clrPtr) begin
                    nextState = IDLE;
                end
            end
            default: begin
                nextState  = CLEAR;
                nextClrPtr = '0;
            end
        endcase
    end

    always_comb begin
        Busy = (state == CLEAR);
    end

    assign wr0Ok = !Busy && WriteEn0 && !((ZERO_REG != 0) && (WriteAddr0 == '0));
    assign wr1Ok = !Busy && WriteEn1 && !((ZERO_REG != 0) && (WriteAddr1 == '0));

    // Storage has no reset so it can map to RAM; port 1 is written last so it wins on a collision.
    always_ff @(posedge CLK) begin
        if (Busy) begin
            mem[clrPtr] <= '0;
        end else begin
            if (wr0Ok) begin
                mem[WriteAddr0] <= WriteData0;
            end
            if (wr1Ok) begin
                mem[WriteAddr1] <= WriteData1;
            end
        end
    end

    for (genvar k = 0; k < N_READ; k++) begin : gLane
        logic [ADDR_W-1:0] rAddr;
        logic [DATA_W-1:0] rData;

        assign rAddr = ReadAddr[k*ADDR_W +: ADDR_W];

        always_comb begin
            rData = mem[rAddr];
`ifdef REGFILE_BYPASS_EN
            if (wr0Ok && (WriteAddr0 == rAddr)) begin
                rData = WriteData0;
            end
            if (wr1Ok && (WriteAddr1 == rAddr)) begin
                rData = WriteData1;
            end
`endif
            if (Busy || ((ZERO_REG != 0) && (rAddr == '0))) begin
                rData = '0;
            end
        end

        assign ReadData[k*DATA_W +: DATA_W] = rData;
    end

endmodule

// File: tb/tb_mips_reg_file_mp.sv
// Directed bench for mips_reg_file_mp with default parameters (32x32, two read lanes, r0 hardwired).
module tb_mips_reg_file_mp;

    logic        CLK        = 1'b0;
    logic        RESET      = 1'b0;
    logic        ClearReq   = 1'b0;
    logic        Busy;
    logic        WriteEn0   = 1'b0;
    logic [4:0]  WriteAddr0 = '0;
    logic [31:0] WriteData0 = '0;
    logic        WriteEn1   = 1'b0;
    logic [4:0]  WriteAddr1 = '0;
    logic [31:0] WriteData1 = '0;
    logic [9:0]  ReadAddr   = '0;
    logic [63:0] ReadData;

    int nCompared   = 0;
    int nMismatched = 0;

    mips_reg_file_mp #(
        .DATA_W  (32),
        .ADDR_W  (5),
        .N_READ  (2),
        .ZERO_REG(1)
    ) dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .ClearReq  (ClearReq),
        .Busy      (Busy),
        .WriteEn0  (WriteEn0),
        .WriteAddr0(WriteAddr0),
        .WriteData0(WriteData0),
        .WriteEn1  (WriteEn1),
        .WriteAddr1(WriteAddr1),
        .WriteData1(WriteData1),
        .ReadAddr  (ReadAddr),
        .ReadData  (ReadData)
    );

    always #5 CLK = ~CLK;

    task automatic cycle();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        int n;
        RESET = 1'b1;
        #1;
        nCompared++;
        if (Busy !== 1'b1) begin
            nMismatched++;
            $display("[TB] FAIL resetBusyImmediate: got %b expected 1", Busy);
        end
        nCompared++;
        if (ReadData !== 64'h0) begin
            nMismatched++;
            $display("[TB] FAIL resetReadZero: got %h expected 0", ReadData);
        end
        repeat (3) cycle();
        RESET = 1'b0;
        n = 0;
        while (Busy === 1'b1 && n < 100) begin
            cycle();
            n++;
        end
        nCompared++;
        if (n !== 32) begin
            nMismatched++;
            $display("[TB] FAIL resetBusyLength: got %0d cycles expected 32", n);
        end
        for (int a = 0; a < 32; a++) begin
            ReadAddr = {5'(31 - a), 5'(a)};
            #1;
            nCompared++;
            if (ReadData !== 64'h0) begin
                nMismatched++;
                $display("[TB] FAIL resetClearedAddr%0d: got %h expected 0", a, ReadData);
            end
        end
    endtask

    task automatic test_dual_write();
        WriteEn0 = 1'b1; WriteAddr0 = 5'd5; WriteData0 = 32'hDEADBEEF;
        WriteEn1 = 1'b1; WriteAddr1 = 5'd7; WriteData1 = 32'h12345678;
        cycle();
        WriteEn0 = 1'b0;
        WriteEn1 = 1'b0;
        ReadAddr = {5'd7, 5'd5};
        #1;
        nCompared++;
        if (ReadData !== {32'h12345678, 32'hDEADBEEF}) begin
            nMismatched++;
            $display("[TB] FAIL dualWrite: got %h expected 12345678deadbeef", ReadData);
        end
    endtask

    task automatic test_same_addr();
        WriteEn0 = 1'b1; WriteAddr0 = 5'd9; WriteData0 = 32'h1111;
        WriteEn1 = 1'b1; WriteAddr1 = 5'd9; WriteData1 = 32'h2222;
        cycle();
        WriteEn0 = 1'b0;
        WriteEn1 = 1'b0;
        ReadAddr = {5'd9, 5'd9};
        #1;
        nCompared++;
        if (ReadData !== {32'h2222, 32'h2222}) begin
            nMismatched++;
            $display("[TB] FAIL samePortPriority: got %h expected 0000222200002222", ReadData);
        end
    endtask

    task automatic test_zero_reg();
        ReadAddr = {5'd9, 5'd0};
        WriteEn0 = 1'b1; WriteAddr0 = 5'd0; WriteData0 = 32'hFFFFFFFF;
        WriteEn1 = 1'b1; WriteAddr1 = 5'd0; WriteData1 = 32'hFFFFFFFF;
        #1;
        nCompared++;
        if (ReadData[31:0] !== 32'h0) begin
            nMismatched++;
            $display("[TB] FAIL zeroRegSameCycle: got %h expected 0", ReadData[31:0]);
        end
        cycle();
        WriteEn0 = 1'b0;
        WriteEn1 = 1'b0;
        #1;
        nCompared++;
        if (ReadData !== {32'h2222, 32'h0}) begin
            nMismatched++;
            $display("[TB] FAIL zeroRegAfter: got %h expected 0000222200000000", ReadData);
        end
    endtask

    task automatic test_bypass();
        logic [31:0] expSame;
        WriteEn0 = 1'b1; WriteAddr0 = 5'd3; WriteData0 = 32'h55;
        cycle();
        ReadAddr = {5'd9, 5'd3};
        WriteData0 = 32'hAA;
`ifdef REGFILE_BYPASS_EN
        expSame = 32'hAA;
`else
        expSame = 32'h55;
`endif
        #1;
        nCompared++;
        if (ReadData !== {32'h2222, expSame}) begin
            nMismatched++;
            $display("[TB] FAIL readDuringWrite: got %h expected %h", ReadData, {32'h2222, expSame});
        end
        cycle();
        WriteEn0 = 1'b0;
        #1;
        nCompared++;
        if (ReadData[31:0] !== 32'hAA) begin
            nMismatched++;
            $display("[TB] FAIL readAfterWrite: got %h expected 000000aa", ReadData[31:0]);
        end
        WriteEn0 = 1'b1; WriteData0 = 32'hB0;
        WriteEn1 = 1'b1; WriteAddr1 = 5'd3; WriteData1 = 32'hB1;
`ifdef REGFILE_BYPASS_EN
        expSame = 32'hB1;
`else
        expSame = 32'hAA;
`endif
        #1;
        nCompared++;
        if (ReadData[31:0] !== expSame) begin
            nMismatched++;
            $display("[TB] FAIL bypassPriority: got %h expected %h", ReadData[31:0], expSame);
        end
        cycle();
        WriteEn0 = 1'b0;
        WriteEn1 = 1'b0;
        #1;
        nCompared++;
        if (ReadData[31:0] !== 32'hB1) begin
            nMismatched++;
            $display("[TB] FAIL priorityCommit: got %h expected 000000b1", ReadData[31:0]);
        end
    endtask

    task automatic test_clear();
        int n;
        for (int a = 1; a < 32; a++) begin
            WriteEn0 = 1'b1; WriteAddr0 = 5'(a); WriteData0 = 32'hA0000000 | 32'(a);
            cycle();
        end
        WriteEn0 = 1'b0;
        ReadAddr = {5'd4, 5'd31};
        #1;
        nCompared++;
        if (ReadData !== {32'hA0000004, 32'hA000001F}) begin
            nMismatched++;
            $display("[TB] FAIL fillRead: got %h expected a0000004a000001f", ReadData);
        end
        ClearReq = 1'b1;
        cycle();
        ClearReq = 1'b0;
        nCompared++;
        if (Busy !== 1'b1) begin
            nMismatched++;
            $display("[TB] FAIL clearStartBusy: got %b expected 1", Busy);
        end
        n = 0;
        while (Busy === 1'b1 && n < 100) begin
            #1;
            nCompared++;
            if (ReadData !== 64'h0) begin
                nMismatched++;
                $display("[TB] FAIL busyReadZero cycle %0d: got %h expected 0", n, ReadData);
            end
            WriteEn0   = (n == 20);
            WriteAddr0 = 5'd4;
            WriteData0 = 32'h44;
            ClearReq   = (n == 10);
            cycle();
            n++;
        end
        WriteEn0 = 1'b0;
        ClearReq = 1'b0;
        nCompared++;
        if (n !== 32) begin
            nMismatched++;
            $display("[TB] FAIL clearBusyLength: got %0d cycles expected 32", n);
        end
        for (int a = 0; a < 32; a++) begin
            ReadAddr = {5'(a ^ 31), 5'(a)};
            #1;
            nCompared++;
            if (ReadData !== 64'h0) begin
                nMismatched++;
                $display("[TB] FAIL clearedAddr%0d: got %h expected 0", a, ReadData);
            end
        end
    endtask

    task automatic test_reset_mid_clear();
        int n;
        ClearReq = 1'b1;
        cycle();
        ClearReq = 1'b0;
        repeat (15) cycle();
        RESET = 1'b1;
        #1;
        nCompared++;
        if (Busy !== 1'b1) begin
            nMismatched++;
            $display("[TB] FAIL midClearResetBusy: got %b expected 1", Busy);
        end
        cycle();
        RESET = 1'b0;
        n = 0;
        while (Busy === 1'b1 && n < 100) begin
            cycle();
            n++;
        end
        nCompared++;
        if (n !== 32) begin
            nMismatched++;
            $display("[TB] FAIL midClearResetLength: got %0d cycles expected 32", n);
        end
    endtask

    task automatic test_back_to_back();
        WriteEn1 = 1'b1; WriteAddr1 = 5'd12; WriteData1 = 32'hCAFEF00D;
        cycle();
        WriteAddr1 = 5'd13; WriteData1 = 32'h0BADC0DE;
        cycle();
        WriteEn1 = 1'b0;
        ReadAddr = {5'd13, 5'd12};
        #1;
        nCompared++;
        if (ReadData !== {32'h0BADC0DE, 32'hCAFEF00D}) begin
            nMismatched++;
            $display("[TB] FAIL backToBack: got %h expected 0badc0decafef00d", ReadData);
        end
    endtask

    initial begin
        #2;
        test_reset();
        test_dual_write();
        test_same_addr();
        test_zero_reg();
        test_bypass();
        test_clear();
        test_reset_mid_clear();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
